kogge_stone_sub_32_pipe: RTL and testbench



---
 rtl/kogge_stone_sub_32_pipe_if.sv | 40 ++++
 rtl/kogge_stone_sub_32_pipe.sv | 121 ++++++++++++
 tb/tb_kogge_stone_sub_32_pipe.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kogge_stone_sub_32_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : kogge_stone_sub_32_pipe_if
// Brief    : Operand/result valid-ready bundle for the pipelined Kogge-Stone
//            subtractor. Flag signals exist only when KS_SUB_FLAGS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface kogge_stone_sub_32_pipe_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] A_reg;
    logic [DATA_WIDTH-1:0] B_reg;
    logic                  Bin_reg;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH:0]   D_reg;
`ifdef KS_SUB_FLAGS_EN
    logic                  zero_flag;
    logic                  ovf_flag;
`endif

    modport master (
        output in_valid, A_reg, B_reg, Bin_reg, out_ready,
        input  in_ready, out_valid, D_reg
`ifdef KS_SUB_FLAGS_EN
        , input zero_flag, ovf_flag
`endif
    );

    modport slave (
        input  in_valid, A_reg, B_reg, Bin_reg, out_ready,
        output in_ready, out_valid, D_reg
`ifdef KS_SUB_FLAGS_EN
        , output zero_flag, ovf_flag
`endif
    );
endinterface
`default_nettype wire

// File: rtl/kogge_stone_sub_32_pipe.sv
`default_nettype none
// ============================================================================
// Module   : kogge_stone_sub_32_pipe
// Brief    : 3-stage pipelined Kogge-Stone subtractor, D = A + ~B + ~Bin with
//            valid/ready on both sides. Define KS_SUB_FLAGS_EN for zero/ovf flags.
// Revision : 1.0 - initial release
// ============================================================================
module kogge_stone_sub_32_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int OUTPUT_WIDTH = DATA_WIDTH + 1
) (
    input wire logic                 CLK,
    input wire logic                 RST,
    kogge_stone_sub_32_pipe_if.slave bus
);
    localparam int c_levels    = $clog2(DATA_WIDTH);
    localparam int c_s2_levels = (c_levels + 1) / 2;

    logic                    w_en;
    logic                    r_s1_valid;
    logic [DATA_WIDTH-1:0]   r_s1_a;
    logic [DATA_WIDTH-1:0]   r_s1_bn;
    logic                    r_s1_cin;
    logic                    r_s2_valid;
    logic [DATA_WIDTH-1:0]   r_s2_g;
    logic [DATA_WIDTH-1:0]   r_s2_p;
    logic [DATA_WIDTH-1:0]   r_s2_p0;
    logic                    r_s2_cin;
    logic                    r_out_valid;
    logic [OUTPUT_WIDTH-1:0] r_d;
    logic [DATA_WIDTH-1:0]   w_c;
    logic [DATA_WIDTH-1:0]   w_diff;
    logic [DATA_WIDTH-1:0]   w_g [0:c_levels];
    logic [DATA_WIDTH-1:0]   w_p [0:c_levels-1];
`ifdef KS_SUB_FLAGS_EN
    logic                    r_s2_a_msb;
    logic                    r_s2_b_msb;
    logic                    r_zero;
    logic                    r_ovf;
`endif

    // The whole pipe moves in lockstep; reset forces acceptance so nothing back-pressures.
    assign w_en         = !r_out_valid || bus.out_ready;
    assign bus.in_ready = RST || w_en;

    // Carry-in folded into bit-0 generate, so group generate G[0:i] is carry c[i].
    assign w_p[0] = r_s1_a ^ r_s1_bn;
    assign w_g[0] = (r_s1_a & r_s1_bn) | DATA_WIDTH'(w_p[0][0] & r_s1_cin);

    for (genvar k = 1; k <= c_levels; k++) begin : g_level
        localparam int c_dist = 1 << (k - 1);
        logic [DATA_WIDTH-1:0] w_gin;
        logic [DATA_WIDTH-1:0] w_pin;

        if (k == c_s2_levels + 1) begin : g_from_reg
            assign w_gin = r_s2_g;
            assign w_pin = r_s2_p;
        end else begin : g_from_comb
            assign w_gin = w_g[k-1];
            assign w_pin = w_p[k-1];
        end

        assign w_g[k] = w_gin | (w_pin & (w_gin << c_dist));

        if (k < c_levels) begin : g_prop
            assign w_p[k] = w_pin & ((w_pin << c_dist) |
                                     DATA_WIDTH'((64'd1 << c_dist) - 64'd1));
        end
    end

    assign w_c    = w_g[c_levels];
    assign w_diff = r_s2_p0 ^ {w_c[DATA_WIDTH-2:0], r_s2_cin};

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s1_valid  <= 1'b0;
            r_s1_a      <= '0;
            r_s1_bn     <= '0;
            r_s1_cin    <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s2_g      <= '0;
            r_s2_p      <= '0;
            r_s2_p0     <= '0;
            r_s2_cin    <= 1'b0;
            r_out_valid <= 1'b0;
            r_d         <= '0;
`ifdef KS_SUB_FLAGS_EN
            r_s2_a_msb  <= 1'b0;
            r_s2_b_msb  <= 1'b0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
`endif
        end else if (w_en) begin
            r_s1_valid  <= bus.in_valid;
            r_s1_a      <= bus.A_reg;
            r_s1_bn     <= ~bus.B_reg;
            r_s1_cin    <= ~bus.Bin_reg;
            r_s2_valid  <= r_s1_valid;
            r_s2_g      <= w_g[c_s2_levels];
            r_s2_p      <= w_p[c_s2_levels];
            r_s2_p0     <= w_p[0];
            r_s2_cin    <= r_s1_cin;
            r_out_valid <= r_s2_valid;
            r_d         <= {~w_c[DATA_WIDTH-1], w_diff};
`ifdef KS_SUB_FLAGS_EN
            r_s2_a_msb  <= r_s1_a[DATA_WIDTH-1];
            r_s2_b_msb  <= ~r_s1_bn[DATA_WIDTH-1];
            r_zero      <= (w_diff == '0);
            r_ovf       <= (r_s2_a_msb ^ r_s2_b_msb) & (r_s2_a_msb ^ w_diff[DATA_WIDTH-1]);
`endif
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.D_reg     = r_d;
`ifdef KS_SUB_FLAGS_EN
    assign bus.zero_flag = r_zero;
    assign bus.ovf_flag  = r_ovf;
`endif
endmodule
`default_nettype wire

// File: tb/tb_kogge_stone_sub_32_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_kogge_stone_sub_32_pipe
// Brief    : Self-checking bench for the pipelined Kogge-Stone subtractor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kogge_stone_sub_32_pipe;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    kogge_stone_sub_32_pipe_if #(.DATA_WIDTH(32)) bus ();

    kogge_stone_sub_32_pipe #(
        .DATA_WIDTH   (32),
        .OUTPUT_WIDTH (33)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    localparam logic [31:0] c_da [0:6] = '{32'd5, 32'd0, 32'hFFFFFFFF, 32'h80000000,
                                           32'h7FFFFFFF, 32'd0, 32'h12345678};
    localparam logic [31:0] c_db [0:6] = '{32'd12, 32'd0, 32'hFFFFFFFF, 32'd1,
                                           32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678};
    localparam logic        c_dbin [0:6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic [32:0] c_dexp [0:6] = '{33'h1FFFFFFF9, 33'h1FFFFFFFF, 33'h000000000,
                                             33'h07FFFFFFF, 33'h180000000, 33'h100000000,
                                             33'h1FFFFFFFF};
    localparam logic        c_dzero [0:6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic        c_dovf  [0:6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic bin);
        return {1'b0, a} - {1'b0, b} - {32'd0, bin};
    endfunction

    task automatic test_reset();
        RST = 1'b1;
        bus.in_valid  = 1'b1;
        bus.A_reg     = 32'd9;
        bus.B_reg     = 32'd3;
        bus.Bin_reg   = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
        tick(); tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        n_cmp++;
        if (bus.D_reg !== 33'h0) begin
            n_fail++; $display("FAIL reset_d_reg: got %h expected 0", bus.D_reg);
        end
`ifdef KS_SUB_FLAGS_EN
        n_cmp++;
        if (bus.zero_flag !== 1'b0 || bus.ovf_flag !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got z=%b o=%b expected 0 0", bus.zero_flag, bus.ovf_flag);
        end
`endif
        RST = 1'b0;
        bus.in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++; $display("FAIL reset_dropped_beat: out_valid got %b expected 0", bus.out_valid);
            end
        end
    endtask

    task automatic test_directed();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = 1'b1;
            bus.A_reg    = c_da[i];
            bus.B_reg    = c_db[i];
            bus.Bin_reg  = c_dbin[i];
            for (int c = 1; c <= 3; c++) begin
                tick();
                bus.in_valid = 1'b0;
                n_cmp++;
                if (bus.out_valid !== (c == 3)) begin
                    n_fail++;
                    $display("FAIL latency vec%0d cyc%0d: out_valid got %b expected %b", i, c, bus.out_valid, (c == 3));
                end
            end
            n_cmp++;
            if (bus.D_reg !== c_dexp[i]) begin
                n_fail++; $display("FAIL directed vec%0d: D_reg got %h expected %h", i, bus.D_reg, c_dexp[i]);
            end
`ifdef KS_SUB_FLAGS_EN
            n_cmp++;
            if (bus.zero_flag !== c_dzero[i] || bus.ovf_flag !== c_dovf[i]) begin
                n_fail++;
                $display("FAIL flags vec%0d: got z=%b o=%b expected z=%b o=%b", i,
                         bus.zero_flag, bus.ovf_flag, c_dzero[i], c_dovf[i]);
            end
`endif
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va   [0:99];
        logic [31:0] vb   [0:99];
        logic        vbin [0:99];
        int rx = 0, first = -1, last = -1;
        for (int i = 0; i < 100; i++) begin
            va[i]   = $urandom;
            vb[i]   = (i % 10 == 3) ? va[i] : $urandom;
            vbin[i] = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 120; cyc++) begin
            if (cyc < 100) begin
                bus.in_valid = 1'b1;
                bus.A_reg    = va[cyc];
                bus.B_reg    = vb[cyc];
                bus.Bin_reg  = vbin[cyc];
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            if (bus.out_valid === 1'b1) begin
                if (rx < 100) begin
                    n_cmp++;
                    if (bus.D_reg !== model(va[rx], vb[rx], vbin[rx])) begin
                        n_fail++;
                        $display("FAIL b2b beat%0d: D_reg got %h expected %h", rx, bus.D_reg,
                                 model(va[rx], vb[rx], vbin[rx]));
                    end
                end
                if (first < 0) first = cyc;
                last = cyc;
                rx++;
            end
        end
        n_cmp++;
        if (rx != 100) begin
            n_fail++; $display("FAIL b2b_count: got %0d results expected 100", rx);
        end
        n_cmp++;
        if (last - first != 99) begin
            n_fail++; $display("FAIL b2b_span: got %0d cycles expected 99", last - first);
        end
    endtask

    task automatic test_stall();
        localparam int c_n = 60;
        logic [31:0] va   [0:c_n-1];
        logic [31:0] vb   [0:c_n-1];
        logic        vbin [0:c_n-1];
        int tx = 0, rx = 0;
        logic stalled = 1'b0;
        logic exp_ready;
        logic [32:0] held = '0;
        for (int i = 0; i < c_n; i++) begin
            va[i]   = $urandom;
            vb[i]   = $urandom;
            vbin[i] = 1'($urandom_range(0, 1));
        end
        for (int cyc = 0; cyc < 1000 && rx < c_n; cyc++) begin
            if (stalled) begin
                n_cmp++;
                if (bus.out_valid !== 1'b1 || bus.D_reg !== held) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v=%b D=%h expected v=1 D=%h", bus.out_valid, bus.D_reg, held);
                end
            end
            bus.out_ready = ($urandom_range(0, 9) >= 4);
            if (tx < c_n) begin
                bus.in_valid = 1'b1;
                bus.A_reg    = va[tx];
                bus.B_reg    = vb[tx];
                bus.Bin_reg  = vbin[tx];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            exp_ready = !(bus.out_valid && !bus.out_ready);
            n_cmp++;
            if (bus.in_ready !== exp_ready) begin
                n_fail++; $display("FAIL stall_in_ready: got %b expected %b", bus.in_ready, exp_ready);
            end
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                n_cmp++;
                if (bus.D_reg !== model(va[rx], vb[rx], vbin[rx])) begin
                    n_fail++;
                    $display("FAIL stall_data beat%0d: D_reg got %h expected %h", rx, bus.D_reg,
                             model(va[rx], vb[rx], vbin[rx]));
                end
                rx++;
            end
            stalled = bus.out_valid && !bus.out_ready;
            held    = bus.D_reg;
            if (bus.in_valid && bus.in_ready) tx++;
            tick();
        end
        n_cmp++;
        if (rx != c_n) begin
            n_fail++; $display("FAIL stall_count: got %0d results expected %0d", rx, c_n);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.A_reg    = 32'd100 + i;
            bus.B_reg    = i;
            bus.Bin_reg  = 1'b0;
            tick();
        end
        RST           = 1'b1;
        bus.out_ready = 1'b0;
        bus.A_reg     = 32'd77;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL midreset_in_ready: got %b expected 1", bus.in_ready);
        end
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.D_reg !== 33'h0) begin
            n_fail++; $display("FAIL midreset_clear: got v=%b D=%h expected v=0 D=0", bus.out_valid, bus.D_reg);
        end
        RST           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++; $display("FAIL midreset_stale: out_valid got %b expected 0", bus.out_valid);
            end
        end
        bus.in_valid = 1'b1;
        bus.A_reg    = 32'd1000;
        bus.B_reg    = 32'd1;
        bus.Bin_reg  = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            bus.in_valid = 1'b0;
            n_cmp++;
            if (bus.out_valid !== (c == 3)) begin
                n_fail++; $display("FAIL postreset_latency cyc%0d: got %b expected %b", c, bus.out_valid, (c == 3));
            end
        end
        n_cmp++;
        if (bus.D_reg !== 33'h0000003E6) begin
            n_fail++; $display("FAIL postreset_data: got %h expected 0000003e6", bus.D_reg);
        end
        tick();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.A_reg     = '0;
        bus.B_reg     = '0;
        bus.Bin_reg   = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
